funtion_unit_seq: RTL

Parametrised, sequential successor to the 8-bit combinational function unit. It performs the same arithmetic, logic and shift operation classes over a `WIDTH`-bit datapath. Shifts and rotates take a multi-bit shift amount and execute iteratively, one bit per cycle. Results and V/C/N/Z status are registered and delivered with a start/busy/done handshake, so the block sits between the register file read ports and the writeback/status register of the CPU datapath.

---
 rtl/funtion_unit_seq_if.sv | 28 ++
 rtl/funtion_unit_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/funtion_unit_seq_if.sv
// Handshake and operand/result bundle for funtion_unit_seq.
interface funtion_unit_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic             start;
    logic [3:0]       FunSel;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] FuntionOut;
    logic             V;
    logic             C;
    logic             N;
    logic             Z;

    modport master (
        output start, FunSel, dataA, dataB, shamt,
        input  busy, done, FuntionOut, V, C, N, Z
    );

    modport slave (
        input  start, FunSel, dataA, dataB, shamt,
        output busy, done, FuntionOut, V, C, N, Z
    );
endinterface

// File: rtl/funtion_unit_seq.sv
// Sequential function unit: arithmetic, logic and iterative shifts with start/busy/done handshake.
// Define FUNIT_BARREL_EN to use a single-cycle barrel shifter instead of the iterative one.
module funtion_unit_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic               clk,
    input logic               rst,
    funtion_unit_seq_if.slave bus
);

    localparam logic [1:0] OpShr = 2'b00;
    localparam logic [1:0] OpShl = 2'b01;
    localparam logic [1:0] OpRor = 2'b10;
    localparam logic [1:0] OpAsr = 2'b11;

    logic [WIDTH-1:0] r_out;
    logic             r_v, r_c, r_n, r_z, r_done;

    logic [WIDTH-1:0] w_x, w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_sh_res;
    logic             w_sh_c;
    logic [WIDTH-1:0] w_imm_res;
    logic             w_imm_c, w_imm_v;

    logic             w_fin_en;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c, w_fin_v;

    // Arithmetic is always one WIDTH+1-bit add; the opcode only picks the addend and carry-in.
    always_comb begin
        w_x   = bus.dataA;
        w_y   = '0;
        w_cin = 1'b0;
        case (bus.FunSel[2:0])
            3'b001:  w_cin = 1'b1;
            3'b010:  w_y = bus.dataB;
            3'b011:  begin w_y = bus.dataB;  w_cin = 1'b1; end
            3'b100:  w_y = ~bus.dataB;
            3'b101:  begin w_y = ~bus.dataB; w_cin = 1'b1; end
            3'b110:  w_y = '1;
            default: w_y = '0;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    end

    always_comb begin
        unique case (bus.FunSel[1:0])
            2'b00:   w_logic = bus.dataA & bus.dataB;
            2'b01:   w_logic = bus.dataA | bus.dataB;
            2'b10:   w_logic = bus.dataA ^ bus.dataB;
            default: w_logic = ~bus.dataA;
        endcase
    end

`ifdef FUNIT_BARREL_EN
    logic [2*WIDTH-1:0] w_rot;
    logic [WIDTH-1:0]   w_asr;
    logic [SHW-1:0]     w_idx_r, w_idx_l;

    always_comb begin
        w_rot   = {bus.dataB, bus.dataB} >> bus.shamt;
        w_asr   = $signed(bus.dataB) >>> bus.shamt;
        w_idx_r = bus.shamt - SHW'(1);
        // Modular negate gives WIDTH-k, the last bit to leave on a left shift.
        w_idx_l = SHW'(0) - bus.shamt;
        unique case (bus.FunSel[1:0])
            OpShr:   w_sh_res = bus.dataB >> bus.shamt;
            OpShl:   w_sh_res = bus.dataB << bus.shamt;
            OpRor:   w_sh_res = w_rot[WIDTH-1:0];
            default: w_sh_res = w_asr;
        endcase
        if (bus.shamt == '0) begin
            w_sh_c = 1'b0;
        end else if (bus.FunSel[1:0] == OpShl) begin
            w_sh_c = bus.dataB[w_idx_l];
        end else begin
            w_sh_c = bus.dataB[w_idx_r];
        end
    end
`else
    always_comb begin
        w_sh_res = bus.dataB;
        w_sh_c   = 1'b0;
    end
`endif

    always_comb begin
        unique case (bus.FunSel[3:2])
            2'b00, 2'b01: begin
                w_imm_res = w_sum[WIDTH-1:0];
                w_imm_c   = w_sum[WIDTH];
                w_imm_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
            end
            2'b10: begin
                w_imm_res = w_logic;
                w_imm_c   = 1'b0;
                w_imm_v   = 1'b0;
            end
            default: begin
                w_imm_res = w_sh_res;
                w_imm_c   = w_sh_c;
                w_imm_v   = 1'b0;
            end
        endcase
    end

`ifdef FUNIT_BARREL_EN
    always_comb begin
        w_fin_en  = bus.start;
        w_fin_res = w_imm_res;
        w_fin_c   = w_imm_c;
        w_fin_v   = w_imm_v;
    end

    assign bus.busy = 1'b0;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_work, w_work_nxt, w_step;
    logic [SHW-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]       r_sop, w_sop_nxt;
    logic             w_step_c;

    always_comb begin
        unique case (r_sop)
            OpShr:   begin w_step = {1'b0, r_work[WIDTH-1:1]};         w_step_c = r_work[0];       end
            OpShl:   begin w_step = {r_work[WIDTH-2:0], 1'b0};         w_step_c = r_work[WIDTH-1]; end
            OpRor:   begin w_step = {r_work[0], r_work[WIDTH-1:1]};    w_step_c = r_work[0];       end
            default: begin w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]}; w_step_c = r_work[0];   end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_sop_nxt   = r_sop;
        w_fin_en    = 1'b0;
        w_fin_res   = w_imm_res;
        w_fin_c     = w_imm_c;
        w_fin_v     = w_imm_v;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if ((bus.FunSel[3:2] == 2'b11) && (bus.shamt != '0)) begin
                        w_state_nxt = StShift;
                        w_work_nxt  = bus.dataB;
                        w_cnt_nxt   = bus.shamt;
                        w_sop_nxt   = bus.FunSel[1:0];
                    end else begin
                        w_fin_en = 1'b1;
                    end
                end
            end
            StShift: begin
                w_work_nxt = w_step;
                w_cnt_nxt  = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_state_nxt = StIdle;
                    w_fin_en    = 1'b1;
                    w_fin_res   = w_step;
                    w_fin_c     = w_step_c;
                    w_fin_v     = 1'b0;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_work  <= '0;
            r_cnt   <= '0;
            r_sop   <= OpShr;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sop   <= w_sop_nxt;
        end
    end

    assign bus.busy = (r_state == StShift);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_v    <= 1'b0;
            r_c    <= 1'b0;
            r_n    <= 1'b0;
            r_z    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin_en;
            if (w_fin_en) begin
                r_out <= w_fin_res;
                r_v   <= w_fin_v;
                r_c   <= w_fin_c;
                r_n   <= w_fin_res[WIDTH-1];
                r_z   <= (w_fin_res == '0);
            end
        end
    end

    assign bus.done       = r_done;
    assign bus.FuntionOut = r_out;
    assign bus.V          = r_v;
    assign bus.C          = r_c;
    assign bus.N          = r_n;
    assign bus.Z          = r_z;

endmodule
